// File: rtl/seg_pkg.sv
// Shared constants for the segment unit: segment register indices and the
// segment-override state encoding.
package seg_pkg;

  localparam int SEG_ES = 0;
  localparam int SEG_CS = 1;
  localparam int SEG_SS = 2;
  localparam int SEG_DS = 3;

  typedef enum logic {
    OVR_IDLE  = 1'b0,
    OVR_ARMED = 1'b1
  } ovr_state_t;

  // True when a select value names one of the implemented segment registers.
  function automatic bit seg_index_ok(input int unsigned sel, input int unsigned num_seg);
    return sel < num_seg;
  endfunction

endpackage

// File: rtl/seg_agu.sv
// Address generation: (segment << SHIFT) + offset, modulo 2^AW, registered
// with one cycle of latency. Address and segment hold while no access is valid.
module seg_agu #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 4,
  parameter int SEL_W = 2,
  localparam int AW   = WIDTH + SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  input  logic [SEL_W-1:0] acc_sel,
  input  logic [WIDTH-1:0] seg_val,
  input  logic [WIDTH-1:0] off,
  output logic             addr_valid,
  output logic [AW-1:0]    addr,
  output logic [SEL_W-1:0] addr_seg
);

  logic [AW-1:0] sum;

  // The carry out of bit AW-1 is dropped, which gives the modulo wrap.
  always_comb begin
    sum = (AW'(seg_val) << SHIFT) + AW'(off);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_valid <= 1'b0;
      addr       <= '0;
      addr_seg   <= '0;
    end else begin
      addr_valid <= acc_valid;
      if (acc_valid) begin
        addr     <= sum;
        addr_seg <= acc_sel;
      end
    end
  end

endmodule

// File: rtl/segment_unit.sv
// Segment register file with optional one-shot segment-override prefix
// (compiled in by SEGMENT_UNIT_OVERRIDE_EN) feeding a registered address generator.
module segment_unit
  import seg_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter int              NUM_SEG  = 4,
  parameter int              SHIFT    = 4,
  parameter logic [WIDTH-1:0] CS_RESET = 16'hFFFF,
  localparam int SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int AW    = WIDTH + SHIFT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [SEL_W-1:0] WSEL,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [SEL_W-1:0] RSEL,
  output logic [WIDTH-1:0] RDATA,
  input  logic             PFX_VALID,
  input  logic [SEL_W-1:0] PFX_SEG,
  input  logic             ACC_VALID,
  input  logic [SEL_W-1:0] ACC_DEFSEG,
  input  logic [WIDTH-1:0] ACC_OFF,
  output logic             ADDR_VALID,
  output logic [AW-1:0]    ADDR,
  output logic [SEL_W-1:0] ADDR_SEG,
  output logic             INT_INHIBIT,
  input  logic             FLUSH,
  output ovr_state_t       dbg_state
);

  // Interface timing: WE, PFX_VALID, ACC_VALID and FLUSH are single-cycle
  // strobes with no ready; each is consumed at the rising edge where it is high.
  // ADDR_VALID pulses one cycle after the ACC_VALID that produced it.

  logic [WIDTH-1:0] seg_q [NUM_SEG];
  logic [SEL_W-1:0] acc_sel;
  logic [WIDTH-1:0] acc_seg_val;

  // Segment registers. Out-of-range write indices match no register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_q[i] <= (i == SEG_CS) ? CS_RESET : '0;
      end
    end else if (WE && seg_index_ok(int'(WSEL), NUM_SEG)) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (WSEL == SEL_W'(i)) seg_q[i] <= WDATA;
      end
    end
  end

  always_comb begin
    RDATA = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (RSEL == SEL_W'(i)) RDATA = seg_q[i];
    end
  end

  // Interrupt shadow follows every SS write by exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RST) INT_INHIBIT <= 1'b0;
    else     INT_INHIBIT <= WE && (WSEL == SEL_W'(SEG_SS));
  end

`ifdef SEGMENT_UNIT_OVERRIDE_EN
  ovr_state_t       state;
  logic [SEL_W-1:0] pfx_q;

  // FLUSH beats a same-cycle prefix; a prefix beats the consuming access so
  // that a new prefix arriving with an access stays armed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= OVR_IDLE;
      pfx_q <= '0;
    end else if (FLUSH) begin
      state <= OVR_IDLE;
    end else if (PFX_VALID) begin
      state <= OVR_ARMED;
      pfx_q <= PFX_SEG;
    end else if (ACC_VALID && state == OVR_ARMED) begin
      state <= OVR_IDLE;
    end
  end

  assign acc_sel   = (state == OVR_ARMED) ? pfx_q : ACC_DEFSEG;
  assign dbg_state = state;
`else
  logic unused_ovr_inputs;
  assign unused_ovr_inputs = ^{PFX_VALID, PFX_SEG, FLUSH};
  assign acc_sel   = ACC_DEFSEG;
  assign dbg_state = OVR_IDLE;
`endif

  // Access reads the registered value, so a same-cycle write is not forwarded.
  always_comb begin
    acc_seg_val = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (acc_sel == SEL_W'(i)) acc_seg_val = seg_q[i];
    end
  end

  seg_agu #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT),
    .SEL_W (SEL_W)
  ) u_agu (
    .clk        (CLK),
    .rst        (RST),
    .acc_valid  (ACC_VALID),
    .acc_sel    (acc_sel),
    .seg_val    (acc_seg_val),
    .off        (ACC_OFF),
    .addr_valid (ADDR_VALID),
    .addr       (ADDR),
    .addr_seg   (ADDR_SEG)
  );

endmodule

// File: tb/tb_segment_unit.sv
// Bench for segment_unit: directed scenarios then random traffic, checked
// against a rule-level model of segments, override prefix and address math.
module tb_segment_unit;
  import seg_pkg::*;

  localparam int WIDTH = 16;
  localparam int SHIFT = 4;
  localparam int SEL_W = 2;
  localparam int AW    = WIDTH + SHIFT;
  localparam int W     = SEL_W + AW;
`ifdef SEGMENT_UNIT_OVERRIDE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST, WE, PFX_VALID, ACC_VALID, FLUSH;
  logic [SEL_W-1:0] WSEL, RSEL, PFX_SEG, ACC_DEFSEG, ADDR_SEG;
  logic [WIDTH-1:0] WDATA, RDATA, ACC_OFF;
  logic             ADDR_VALID, INT_INHIBIT;
  logic [AW-1:0]    ADDR;
  ovr_state_t       dbg_state;

  segment_unit dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WSEL(WSEL), .WDATA(WDATA),
    .RSEL(RSEL), .RDATA(RDATA), .PFX_VALID(PFX_VALID), .PFX_SEG(PFX_SEG),
    .ACC_VALID(ACC_VALID), .ACC_DEFSEG(ACC_DEFSEG), .ACC_OFF(ACC_OFF),
    .ADDR_VALID(ADDR_VALID), .ADDR(ADDR), .ADDR_SEG(ADDR_SEG),
    .INT_INHIBIT(INT_INHIBIT), .FLUSH(FLUSH), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- model / scoreboard ----------------
  int unsigned m_seg [4];
  bit          m_armed;
  int unsigned m_lat;
  bit          exp_valid, exp_inh;
  logic [W-1:0] exp_q[$];
  logic [AW-1:0]    last_addr;
  logic [SEL_W-1:0] last_seg;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int unsigned use_sel;
    longint unsigned a;
    if (RST) begin
      m_seg = '{0, 16'hFFFF, 0, 0};
      m_armed = 0; m_lat = 0;
      exp_valid = 0; exp_inh = 0;
      exp_q.delete();
      last_addr = '0; last_seg = '0;
    end else begin
      exp_valid = ACC_VALID;
      if (ACC_VALID) begin
        use_sel = (OVR && m_armed) ? m_lat : int'(ACC_DEFSEG);
        a = (longint'(m_seg[use_sel]) * (64'd1 << SHIFT) + ACC_OFF) % (64'd1 << AW);
        exp_q.push_back({SEL_W'(use_sel), AW'(a)});
      end
      if (OVR) begin
        if (FLUSH) m_armed = 0;
        else if (PFX_VALID) begin m_armed = 1; m_lat = PFX_SEG; end
        else if (ACC_VALID) m_armed = 0;
      end
      exp_inh = WE && (WSEL == 2);
      if (WE) m_seg[WSEL] = WDATA;
    end
    @(posedge CLK); #1;
    chk("addr_valid", ADDR_VALID, exp_valid);
    if (exp_valid) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else {last_seg, last_addr} = exp_q.pop_front();
    end
    chk("addr", ADDR, last_addr);
    chk("addr_seg", ADDR_SEG, last_seg);
    chk("int_inhibit", INT_INHIBIT, exp_inh);
    chk("dbg_state", dbg_state == OVR_ARMED, m_armed);
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    RST = 0; WE = 0; WSEL = 0; WDATA = 0; PFX_VALID = 0; PFX_SEG = 0;
    ACC_VALID = 0; ACC_DEFSEG = 0; ACC_OFF = 0; FLUSH = 0;
  endtask

  task automatic wr(input int sel, input logic [WIDTH-1:0] d);
    idle(); WE = 1; WSEL = SEL_W'(sel); WDATA = d; tick();
  endtask

  task automatic acc(input int def, input logic [WIDTH-1:0] off);
    idle(); ACC_VALID = 1; ACC_DEFSEG = SEL_W'(def); ACC_OFF = off; tick();
  endtask

  task automatic pfx(input int sel);
    idle(); PFX_VALID = 1; PFX_SEG = SEL_W'(sel); tick();
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      RSEL = SEL_W'(i); #1;
      chk("rdata", RDATA, m_seg[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(); RSEL = 0;
    RST = 1; tick(); tick();
    idle(); check_regs();
    chk("reset_cs", m_seg[1], 32'hFFFF);

    // DS base, then wrap
    wr(SEG_DS, 16'h1234);
    acc(SEG_DS, 16'h0010);
    idle(); tick();
    chk("ds_addr_const", ADDR, 20'h12350);
    chk("ds_seg_const", ADDR_SEG, 3);
    wr(SEG_DS, 16'hFFFF);
    acc(SEG_DS, 16'h0020);
    chk("wrap_const", ADDR, 20'h00010);

    // override consumed by a single access
    wr(SEG_ES, 16'h2000);
    wr(SEG_DS, 16'h1234);
    pfx(SEG_ES);
    acc(SEG_DS, 16'h0000);
    chk("ovr_first_const", ADDR, OVR ? 20'h20000 : 20'h12340);
    acc(SEG_DS, 16'h0000);
    chk("ovr_second_const", ADDR, 20'h12340);

    // flush cancels a pending prefix
    pfx(SEG_CS);
    idle(); FLUSH = 1; tick();
    acc(SEG_SS, 16'h0004);
    chk("flush_seg_const", ADDR_SEG, 2);

    // same-cycle write is not forwarded
    idle(); WE = 1; WSEL = SEG_DS; WDATA = 16'h0500;
    ACC_VALID = 1; ACC_DEFSEG = SEG_DS; ACC_OFF = 16'h0001; tick();
    chk("no_forward_const", ADDR, 20'h12341);

    // interrupt shadow, back-to-back, then reset mid-sequence
    wr(SEG_SS, 16'h0100);
    chk("inh1_const", INT_INHIBIT, 1);
    wr(SEG_SS, 16'h0200);
    chk("inh2_const", INT_INHIBIT, 1);
    idle(); tick();
    chk("inh_off_const", INT_INHIBIT, 0);
    wr(SEG_SS, 16'h0300);
    idle(); RST = 1; WE = 1; WSEL = SEG_SS; ACC_VALID = 1; PFX_VALID = 1; tick();
    chk("inh_rst_const", INT_INHIBIT, 0);
    idle(); check_regs();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      RST        = ($urandom_range(99) < 3);
      WE         = ($urandom_range(99) < 30);
      WSEL       = SEL_W'($urandom_range(3));
      WDATA      = WIDTH'($urandom);
      PFX_VALID  = ($urandom_range(99) < 20);
      PFX_SEG    = SEL_W'($urandom_range(3));
      ACC_VALID  = ($urandom_range(99) < 50);
      ACC_DEFSEG = SEL_W'($urandom_range(3));
      ACC_OFF    = WIDTH'($urandom);
      FLUSH      = ($urandom_range(99) < 10);
      tick();
      if (n % 16 == 0) check_regs();
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
